// File: rtl/add_share_arb_pkg.sv
// Shared types and widths for the add_share_arb adder-sharing arbiter.
package add_share_arb_pkg;

    localparam int DATA_W     = 32;
    localparam int PERF_CNT_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SUB2 = 1'b1
    } state_t;

endpackage

// File: rtl/add_share_arb_rr_arbiter.sv
// Round-robin arbiter: the winner is the first request at or after pointer+1,
// and the pointer moves to the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = idx_o;
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/std_Add.sv
// 32-bit combinational adder, sum wraps modulo 2^32, no carry in or out.
module std_Add
    import add_share_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/add_share_arb.sv
// Shares one std_Add between NUM_REQ requesters; SUB runs as two passes (~b+1, then a+tmp).
// States: IDLE | arbitrate, ADD or SUB pass 1 ; SUB2 | SUB pass 2, wait for a free slot.
// Optional per-requester grant counters with `define ADD_SHARE_ARB_PERF_EN.
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum
`ifdef ADD_SHARE_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [DATA_W-1:0]   tmp_q, tmp_d;
    logic [DATA_W-1:0]   a_lat_q, a_lat_d;
    logic [ID_W-1:0]     id_lat_q, id_lat_d;

    logic                slot_free;
    logic                arb_en;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                granted;
    logic                win_op;
    logic [DATA_W-1:0]   win_a, win_b;
    logic [DATA_W-1:0]   add_a, add_b, add_sum;

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign arb_en    = !rst && (state_q == IDLE) && slot_free;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign granted   = |gnt;
    assign req_ready = gnt;
    assign win_op    = req_op[gnt_idx];
    assign win_a     = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
    assign win_b     = req_b[int'(gnt_idx)*DATA_W +: DATA_W];

    // Operands are parked at zero when nothing uses the adder.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state_q == SUB2) begin
            add_a = a_lat_q;
            add_b = tmp_q;
        end else if (granted) begin
            if (win_op == OP_SUB) begin
                add_a = ~win_b;
                add_b = DATA_W'(1);
            end else begin
                add_a = win_a;
                add_b = win_b;
            end
        end
    end

    std_Add u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        tmp_d       = tmp_q;
        a_lat_d     = a_lat_q;
        id_lat_d    = id_lat_q;
        case (state_q)
            IDLE: begin
                if (granted && (win_op == OP_SUB)) begin
                    tmp_d    = add_sum;
                    a_lat_d  = win_a;
                    id_lat_d = ID_W'(gnt_idx);
                    state_d  = SUB2;
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_d = 1'b0;
                    end
                end else if (granted) begin
                    rsp_sum_d   = add_sum;
                    rsp_id_d    = ID_W'(gnt_idx);
                    rsp_valid_d = 1'b1;
                end else if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            SUB2: begin
                if (slot_free) begin
                    rsp_sum_d   = add_sum;
                    rsp_id_d    = id_lat_q;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            tmp_q       <= '0;
            a_lat_q     <= '0;
            id_lat_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            tmp_q       <= tmp_d;
            a_lat_q     <= a_lat_d;
            id_lat_q    <= id_lat_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

`ifdef ADD_SHARE_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (perf_q[i] != '1)) begin
                    perf_q[i] <= perf_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = perf_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_add_share_arb;

    localparam int N    = 4;
    localparam int ID_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_op;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_sum;
`ifdef ADD_SHARE_ARB_PERF_EN
    logic [N*16-1:0]   perf_grant_cnt;
`endif

    add_share_arb #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADD_SHARE_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending SUB result, response slot, priority pointer, grant counts.
    bit          m_init = 1'b0;
    int          m_ptr;
    bit          m_valid;
    int          m_id;
    logic [31:0] m_sum;
    bit          m_pend;
    int          m_pid;
    logic [31:0] m_pres;
    int          m_cnt [N];
    logic [N-1:0] acc_last = '0;
    bit          rand_en = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        int           w;
        bit           slot;
        logic [31:0]  ai, bi;
        er   = '0;
        w    = -1;
        slot = !m_valid || rsp_ready;
        if (!rst && !m_pend && slot) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        if (w >= 0) er[w] = 1'b1;

        if (m_init) begin
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
            end
`ifdef ADD_SHARE_ARB_PERF_EN
            for (int i = 0; i < N; i++) chk("perf_cnt", 64'(perf_grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        end
        acc_last = req_valid & req_ready;

        if (rst) begin
            m_init  = 1'b1;
            m_ptr   = N - 1;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_pend) begin
            if (slot) begin
                m_valid = 1'b1;
                m_id    = m_pid;
                m_sum   = m_pres;
                m_pend  = 1'b0;
            end
        end else if (w >= 0) begin
            ai = req_a[w*32 +: 32];
            bi = req_b[w*32 +: 32];
            m_ptr = w;
            if (m_cnt[w] < 65535) m_cnt[w]++;
            if (req_op[w]) begin
                m_pend = 1'b1;
                m_pid  = w;
                m_pres = ai - bi;
                if (m_valid && rsp_ready) m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_id    = w;
                m_sum   = ai + bi;
            end
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Random requesters honour the hold-while-not-accepted rule.
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            rst       = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc_last[i]) begin
                    req_valid[i]       = ($urandom_range(0, 2) != 0);
                    req_op[i]          = $urandom_range(0, 1);
                    req_a[i*32 +: 32]  = rnd_op();
                    req_b[i*32 +: 32]  = rnd_op();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_op[i]         = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset values, then a single ADD.
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        chk("add_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("add_valid", 64'(rsp_valid), 64'd1);
        chk("add_id", 64'(rsp_id), 64'd0);
        chk("add_sum", 64'(rsp_sum), 64'd12);

        // Back-to-back ADDs from all requesters rotate 0,1,2,3,0.
        step();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(100 + i), 32'(i));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(1 << (c % 4)));
            if (c > 0) begin
                chk("rr_id", 64'(rsp_id), 64'((c - 1) % 4));
                chk("rr_sum", 64'(rsp_sum), 64'(100 + 2 * ((c - 1) % 4)));
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_id_last", 64'(rsp_id), 64'd0);
        chk("rr_sum_last", 64'(rsp_sum), 64'd100);

        // SUB 0-1 from requester 2; no grants during the second pass.
        step();
        do_reset();
        set_req(2, 1'b1, 1'b1, 32'd0, 32'd1);
        @(negedge clk);
        chk("sub_grant", 64'(req_ready), 64'b0100);
        step();
        set_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(0, 1'b1, 1'b0, 32'd1, 32'd1);
        set_req(1, 1'b1, 1'b0, 32'd1, 32'd1);
        set_req(3, 1'b1, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        chk("sub2_no_grant", 64'(req_ready), 64'd0);
        chk("sub2_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        @(negedge clk);
        chk("sub_valid", 64'(rsp_valid), 64'd1);
        chk("sub_id", 64'(rsp_id), 64'd2);
        chk("sub_sum", 64'(rsp_sum), 64'hFFFF_FFFF);
        chk("sub_next_grant", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("after_sub_id", 64'(rsp_id), 64'd3);
        chk("after_sub_sum", 64'(rsp_sum), 64'd2);

        // Wrapping ADD held under backpressure, then grant in the drain cycle.
        step();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        chk("bp_grant", 64'(req_ready), 64'b0001);
        step();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'd3, 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_sum", 64'(rsp_sum), 64'd1);
            chk("bp_no_grant", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("drain_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("drain_valid", 64'(rsp_valid), 64'd1);
        chk("drain_id", 64'(rsp_id), 64'd1);
        chk("drain_sum", 64'(rsp_sum), 64'd7);

        // Reset during the second SUB pass discards it and restores priority.
        step();
        do_reset();
        set_req(3, 1'b1, 1'b1, 32'd10, 32'd3);
        @(negedge clk);
        chk("rsub_grant", 64'(req_ready), 64'b1000);
        step();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("rsub_rst_ready", 64'(req_ready), 64'd0);
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'd6, 32'd6);
        set_req(3, 1'b1, 1'b0, 32'd6, 32'd1);
        @(negedge clk);
        chk("rsub_no_rsp", 64'(rsp_valid), 64'd0);
        chk("rsub_grant0", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rsub_id", 64'(rsp_id), 64'd0);
        chk("rsub_sum", 64'(rsp_sum), 64'd12);

        // Randomized traffic against the model.
        step();
        rand_en = 1'b1;
        repeat (3000) @(posedge clk);
        rand_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
